segment_collector: RTL and testbench
====================================

# segment_collector

Input framing stage directly upstream of the demodulator's multiply-accumulate chain. Accepts a serial stream of Q16.16 samples over a valid/ready handshake and packs each group of NUM_SEG consecutive samples into a parallel register bank. The bank drives the demodulator's segment_0 … segment_9 inputs together with a frame-valid flag. A shadow bank lets the next frame fill while the current one is held, and a frame_start marker realigns framing after a slip.

## Interface
- DATA_W, 32, sample width (Q16.16 signed; passed through untouched)
- NUM_SEG, 10, samples per frame (fixed to 10 by the package; the port list matches)
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset; the clock and reset are the only clocking/reset inputs
- sample_in  input  DATA_W  incoming sample
- sample_valid  input  1  sample_in is valid this cycle
- frame_start  input  1  qualifies the current beat as the first sample of a frame; ignored unless sample_valid
- sample_ready  output  1  collector can accept a beat this cycle
- segment_0 … segment_9  output  DATA_W each  output bank; segment_k is the k-th sample of the frame
- segments_valid  output  1  output bank holds a complete, unconsumed frame
- segments_ready  input  1  downstream consumes the bank this cycle
- sync_err_cnt  output  8  saturating count of frame realignments

## Operation
- Beat accepted iff sample_valid && sample_ready; the write index idx (0..NUM_SEG-1) advances and wraps 9→0.
- Beats with idx 0..8 write shadow[idx].
- On the beat at idx 9, one of two things happens:
  - The output bank is free (segments_valid==0, or segments_valid && segments_ready this cycle): load segment_0..8 from shadow[0..8] and segment_9 from sample_in; set segments_valid.
  - Otherwise: write shadow[9] and set shadow_full.
- While shadow_full==1:
  - sample_ready=0.
  - On the output handshake, the bank loads shadow[0..9] on that same edge, segments_valid stays 1, and shadow_full clears.
- Output handshake with no new frame pending: segments_valid clears on that edge. segment_* hold their last values and are not zeroed.
- frame_start on an accepted beat:
  - The beat is written at index 0 and idx becomes 1.
  - If idx was nonzero before the beat, the partial frame is discarded and sync_err_cnt increments, saturating at 255.
  - If idx was 0, the beat is normal and there is no error.
- A beat at idx 0 without frame_start is accepted normally (free-running framing).
- Output bank contents change only on a load edge. They never change while segments_valid==1 and segments_ready==0.
- sample_ready = reset && !shadow_full.

## Timing
- Reset value of every register is 0: idx, shadow_full, segments_valid, segment_0..9, sync_err_cnt.
- sample_ready is 0 while reset==0 and 1 on the first cycle after release.
- Reset mid-frame discards the partial frame and any pending shadow frame. There is no error count.
- Latency: segments_valid rises on the edge that accepts the 10th beat, so it is visible 1 cycle after that beat.
- The 10th beat and the output handshake in the same cycle give a zero-bubble bank swap; segments_valid stays 1 continuously.
- With shadow_full set, an output handshake at edge N lets sample_ready rise in cycle N+1.
- Sustained throughput is 1 beat/cycle when downstream consumes one frame per 10 cycles.

## Structure
- Package seg_pkg holds:
  - NUM_SEG=10
  - IDX_W=4
  - DEFAULT_DATA_W=32
  - the typedef for a DATA_W sample word
  - SYNC_CNT_MAX=255
- Sub-module segment_bank: NUM_SEG×DATA_W register array with a per-entry write enable and a bulk-load port. It is instantiated twice: once as the shadow bank and once as the output bank.
- All control logic (idx, shadow_full, valid, counter) lives in the top of segment_collector.

## Test plan
- Reset: hold reset=0 for 3 cycles with sample_valid=1 and sample_in=0x1234.
  - Required: sample_ready=0, nothing accepted, all outputs 0.
- Clean frame: stream 1..10 back-to-back with segments_ready=1.
  - Required: segments_valid=1 exactly 1 cycle after the beat carrying 10; segment_k=k+1; valid low the following cycle.
- Backpressure: segments_ready=0; stream 1..20.
  - Required: the bank shows 1..10 and holds; sample_ready=0 after beat 20; beat 21 stalls.
  - Then raise segments_ready for 1 cycle. Required: the next cycle shows 11..20 with segments_valid still 1, and sample_ready=1.
- Zero-bubble swap: frame A is held; assert segments_ready in the same cycle as the 10th beat of frame B.
  - Required: B is loaded on that edge and segments_valid never drops.
- Resync: send 4 beats, then a frame_start beat of 0xA5, then 9 beats.
  - Required: sync_err_cnt=1 and segment_0=0xA5.
  - Repeat the slip 300 times. Required: sync_err_cnt=255.
- Reset mid-frame: after 6 beats, pulse reset=0 for 1 cycle, then send 10 beats 0x100..0x109.
  - Required: segment_0=0x100, segment_9=0x109, sync_err_cnt=0.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the segment_collector framing stage.
//   NUM_SEG        samples per frame (one per demodulator segment input)
//   IDX_W          width of the frame write index (covers 0..NUM_SEG-1)
//   DEFAULT_DATA_W Q16.16 sample width
//   SYNC_CNT_MAX   saturation value of the realignment counter
package seg_pkg;
  localparam int NUM_SEG        = 10;
  localparam int IDX_W          = 4;
  localparam int DEFAULT_DATA_W = 32;
  localparam int SYNC_CNT_MAX   = 255;

  typedef logic [DEFAULT_DATA_W-1:0] sample_t;
endpackage

// File: rtl/segment_bank.sv
// segment_bank: NUM_SEG x DATA_W register array.
//   clk, reset       rising-edge clock, synchronous active-low reset (clears all entries)
//   wr_en[k]         write wr_data into entry k this edge
//   wr_data          single-entry write data
//   load_en          replace every entry with load_data this edge (wins over wr_en)
//   load_data        bulk-load data, entry k in slice k
//   bank             current contents, entry k in slice k
module segment_bank
  import seg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SEG-1:0]               wr_en,
  input  logic [DATA_W-1:0]                wr_data,
  input  logic                             load_en,
  input  logic [NUM_SEG-1:0][DATA_W-1:0]   load_data,
  output logic [NUM_SEG-1:0][DATA_W-1:0]   bank
);

  logic [NUM_SEG-1:0][DATA_W-1:0] bank_d;
  logic [NUM_SEG-1:0][DATA_W-1:0] bank_q;

  always_comb begin
    bank_d = bank_q;
    if (load_en) begin
      bank_d = load_data;
    end else begin
      for (int k = 0; k < NUM_SEG; k++) begin
        if (wr_en[k]) bank_d[k] = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) bank_q <= '0;
    else        bank_q <= bank_d;
  end

  assign bank = bank_q;

endmodule

// File: rtl/segment_collector.sv
// segment_collector: packs a serial Q16.16 sample stream into NUM_SEG parallel
// segment outputs for the demodulator MAC chain.
//   clk, reset         rising-edge clock, synchronous active-low reset
//   sample_in/valid    upstream beat; frame_start marks the first sample of a frame
//   sample_ready       collector can take a beat (low while a second frame is parked)
//   segment_0..9       output bank, segment_k = k-th sample of the frame
//   segments_valid     output bank holds a complete, unconsumed frame
//   segments_ready     downstream consumes the bank this cycle
//   sync_err_cnt       saturating count of frame realignments
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Valid never depends on ready; once segments_valid is high the bank is
// frozen until the edge where segments_ready is also high.
//
// Two banks: beats 0..8 always land in the shadow bank. The 10th beat either
// goes straight into the output bank together with shadow[0..8] (bank free),
// or completes the shadow frame and parks it (shadow_full) until downstream
// consumes the current output frame.
module segment_collector
  import seg_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  input  logic              frame_start,
  output logic              sample_ready,
  output logic [DATA_W-1:0] segment_0,
  output logic [DATA_W-1:0] segment_1,
  output logic [DATA_W-1:0] segment_2,
  output logic [DATA_W-1:0] segment_3,
  output logic [DATA_W-1:0] segment_4,
  output logic [DATA_W-1:0] segment_5,
  output logic [DATA_W-1:0] segment_6,
  output logic [DATA_W-1:0] segment_7,
  output logic [DATA_W-1:0] segment_8,
  output logic [DATA_W-1:0] segment_9,
  output logic              segments_valid,
  input  logic              segments_ready,
  output logic [7:0]        sync_err_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);
  localparam logic [7:0]       CNT_MAX  = 8'(SYNC_CNT_MAX);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             shadow_full_q, shadow_full_d;
  logic             segments_valid_q, segments_valid_d;
  logic [7:0]       sync_err_cnt_q, sync_err_cnt_d;

  logic             accept;
  logic             out_hs;
  logic             bank_free;
  logic [IDX_W-1:0] eff_idx;

  logic [NUM_SEG-1:0]             shadow_wr_en;
  logic [NUM_SEG-1:0][DATA_W-1:0] shadow_bank;
  logic                           out_load;
  logic [NUM_SEG-1:0][DATA_W-1:0] out_load_data;
  logic [NUM_SEG-1:0][DATA_W-1:0] out_bank;

  assign sample_ready = reset && !shadow_full_q;

  always_comb begin
    accept    = sample_valid && sample_ready;
    out_hs    = segments_valid_q && segments_ready;
    bank_free = !segments_valid_q || segments_ready;
    // frame_start forces the beat into slot 0 regardless of where framing was.
    eff_idx   = frame_start ? '0 : idx_q;

    idx_d            = idx_q;
    shadow_full_d    = shadow_full_q;
    segments_valid_d = segments_valid_q;
    sync_err_cnt_d   = sync_err_cnt_q;
    shadow_wr_en     = '0;
    out_load         = 1'b0;

    if (accept) begin
      if (frame_start && (idx_q != '0) && (sync_err_cnt_q != CNT_MAX)) begin
        sync_err_cnt_d = sync_err_cnt_q + 8'd1;
      end
      if (eff_idx == LAST_IDX) begin
        idx_d = '0;
        if (bank_free) begin
          out_load         = 1'b1;
          segments_valid_d = 1'b1;
        end else begin
          shadow_wr_en[NUM_SEG-1] = 1'b1;
          shadow_full_d           = 1'b1;
        end
      end else begin
        shadow_wr_en[eff_idx] = 1'b1;
        idx_d                 = eff_idx + 1'b1;
      end
    end

    // accept is always 0 while shadow_full_q, so these two loads never collide.
    if (shadow_full_q && out_hs) begin
      out_load         = 1'b1;
      segments_valid_d = 1'b1;
      shadow_full_d    = 1'b0;
    end else if (out_hs && !out_load) begin
      segments_valid_d = 1'b0;
    end

    // Parked frame: take all of shadow. Direct load: last sample comes from the bus.
    out_load_data = shadow_bank;
    if (!shadow_full_q) out_load_data[NUM_SEG-1] = sample_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q            <= '0;
      shadow_full_q    <= 1'b0;
      segments_valid_q <= 1'b0;
      sync_err_cnt_q   <= '0;
    end else begin
      idx_q            <= idx_d;
      shadow_full_q    <= shadow_full_d;
      segments_valid_q <= segments_valid_d;
      sync_err_cnt_q   <= sync_err_cnt_d;
    end
  end

  segment_bank #(.DATA_W(DATA_W)) u_shadow_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (shadow_wr_en),
    .wr_data   (sample_in),
    .load_en   (1'b0),
    .load_data ('0),
    .bank      (shadow_bank)
  );

  segment_bank #(.DATA_W(DATA_W)) u_out_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     ('0),
    .wr_data   ('0),
    .load_en   (out_load),
    .load_data (out_load_data),
    .bank      (out_bank)
  );

  assign segment_0      = out_bank[0];
  assign segment_1      = out_bank[1];
  assign segment_2      = out_bank[2];
  assign segment_3      = out_bank[3];
  assign segment_4      = out_bank[4];
  assign segment_5      = out_bank[5];
  assign segment_6      = out_bank[6];
  assign segment_7      = out_bank[7];
  assign segment_8      = out_bank[8];
  assign segment_9      = out_bank[9];
  assign segments_valid = segments_valid_q;
  assign sync_err_cnt   = sync_err_cnt_q;

endmodule

// File: tb/tb_segment_collector.sv
// tb_segment_collector: directed + random bench for segment_collector.
module tb_segment_collector;
  import seg_pkg::*;

  localparam int DW = DEFAULT_DATA_W;
  localparam int BW = NUM_SEG * DW;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          frame_start;
  logic          sample_ready;
  logic [DW-1:0] segment_0, segment_1, segment_2, segment_3, segment_4;
  logic [DW-1:0] segment_5, segment_6, segment_7, segment_8, segment_9;
  logic          segments_valid;
  logic          segments_ready;
  logic [7:0]    sync_err_cnt;

  always #5 clk = ~clk;

  segment_collector #(.DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .frame_start    (frame_start),
    .sample_ready   (sample_ready),
    .segment_0      (segment_0),
    .segment_1      (segment_1),
    .segment_2      (segment_2),
    .segment_3      (segment_3),
    .segment_4      (segment_4),
    .segment_5      (segment_5),
    .segment_6      (segment_6),
    .segment_7      (segment_7),
    .segment_8      (segment_8),
    .segment_9      (segment_9),
    .segments_valid (segments_valid),
    .segments_ready (segments_ready),
    .sync_err_cnt   (sync_err_cnt)
  );

  logic [BW-1:0] bank_now;
  assign bank_now = {segment_9, segment_8, segment_7, segment_6, segment_5,
                     segment_4, segment_3, segment_2, segment_1, segment_0};

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] frame_buf [NUM_SEG];
  int            tb_idx   = 0;
  int            exp_err  = 0;

  task automatic check_val(input string tag, input logic [BW-1:0] got,
                           input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] seq_frame(input logic [DW-1:0] first);
    logic [BW-1:0] f;
    for (int k = 0; k < NUM_SEG; k++) f[k*DW +: DW] = first + DW'(k);
    return f;
  endfunction

  // Reference framing model, advanced only on accepted beats.
  task automatic model_beat(input logic [DW-1:0] data, input logic fs);
    logic [BW-1:0] f;
    if (fs) begin
      if (tb_idx != 0 && exp_err < 255) exp_err++;
      tb_idx = 0;
    end
    frame_buf[tb_idx] = data;
    if (tb_idx == NUM_SEG - 1) begin
      for (int k = 0; k < NUM_SEG; k++) f[k*DW +: DW] = frame_buf[k];
      exp_q.push_back(f);
      tb_idx = 0;
    end else begin
      tb_idx++;
    end
  endtask

  // Output monitor: compare on every output handshake, and check the bank
  // stays frozen across any edge where it was valid but not consumed.
  logic          hold_prev = 1'b0;
  logic [BW-1:0] prev_bank = '0;
  always @(negedge clk) begin
    if (hold_prev) check_val("bank_hold", bank_now, prev_bank);
    if (reset && segments_valid && segments_ready) begin
      check_val("sb_pending", BW'(exp_q.size() != 0), BW'(1));
      if (exp_q.size() != 0) check_val("sb_frame", bank_now, exp_q.pop_front());
    end
    hold_prev = reset && segments_valid && !segments_ready;
    prev_bank = bank_now;
  end

  // ---------------- driver ----------------
  task automatic send_beat(input logic [DW-1:0] data, input logic fs);
    logic acc;
    acc          = 1'b0;
    sample_valid = 1'b1;
    sample_in    = data;
    frame_start  = fs;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = sample_ready;
      @(posedge clk);
      #1;
    end
    check_val("beat_accept", BW'(acc), BW'(1));
    if (acc) model_beat(data, fs);
    sample_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset          = 1'b0;
    sample_valid   = 1'b1;
    sample_in      = 32'h1234;
    frame_start    = 1'b0;
    segments_ready = 1'b0;

    // Reset: nothing accepted, everything zero.
    repeat (3) begin
      @(negedge clk);
      check_val("rst_ready", BW'(sample_ready), '0);
      check_val("rst_valid", BW'(segments_valid), '0);
      check_val("rst_bank", bank_now, '0);
      check_val("rst_err", BW'(sync_err_cnt), '0);
    end
    @(posedge clk); #1;
    reset        = 1'b1;
    sample_valid = 1'b0;
    @(negedge clk);
    check_val("rel_ready", BW'(sample_ready), BW'(1));
    check_val("rel_valid", BW'(segments_valid), '0);

    // Clean frame.
    @(posedge clk); #1;
    segments_ready = 1'b1;
    for (int i = 1; i <= 9; i++) send_beat(DW'(i), 1'b0);
    check_val("clean_pre_valid", BW'(segments_valid), '0);
    send_beat(DW'(10), 1'b0);
    @(negedge clk);
    check_val("clean_valid", BW'(segments_valid), BW'(1));
    check_val("clean_bank", bank_now, seq_frame(DW'(1)));
    @(negedge clk);
    check_val("clean_valid_drop", BW'(segments_valid), '0);

    // Backpressure: two frames, second parked in shadow.
    @(posedge clk); #1;
    segments_ready = 1'b0;
    for (int i = 1; i <= 20; i++) send_beat(DW'(i), 1'b0);
    sample_valid = 1'b1;
    sample_in    = DW'(21);
    repeat (3) begin
      @(negedge clk);
      check_val("bp_ready_low", BW'(sample_ready), '0);
      check_val("bp_bank", bank_now, seq_frame(DW'(1)));
      check_val("bp_valid", BW'(segments_valid), BW'(1));
    end
    @(posedge clk); #1;
    sample_valid   = 1'b0;
    segments_ready = 1'b1;
    @(posedge clk); #1;
    segments_ready = 1'b0;
    @(negedge clk);
    check_val("bp_swap_bank", bank_now, seq_frame(DW'(11)));
    check_val("bp_swap_valid", BW'(segments_valid), BW'(1));
    check_val("bp_ready_back", BW'(sample_ready), BW'(1));

    // Zero-bubble swap: frame 11..20 held, frame B's last beat meets the handshake.
    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) send_beat(DW'(32'h200 + i), 1'b0);
    check_val("zb_held_valid", BW'(segments_valid), BW'(1));
    segments_ready = 1'b1;
    send_beat(DW'(32'h209), 1'b0);
    segments_ready = 1'b0;
    check_val("zb_valid", BW'(segments_valid), BW'(1));
    check_val("zb_bank", bank_now, seq_frame(DW'(32'h200)));
    segments_ready = 1'b1;
    @(posedge clk); #1;
    segments_ready = 1'b0;
    @(negedge clk);
    check_val("zb_drain_valid", BW'(segments_valid), '0);

    // Resync: 4 stray beats, frame_start 0xA5, 9 more beats; repeated to saturate.
    @(posedge clk); #1;
    segments_ready = 1'b1;
    for (int r = 0; r < 301; r++) begin
      for (int i = 0; i < 4; i++) send_beat(DW'($urandom), 1'b0);
      send_beat(DW'(32'hA5), 1'b1);
      for (int i = 0; i < 9; i++) send_beat(DW'($urandom), 1'b0);
      check_val("rs_seg0", BW'(segment_0), BW'(32'hA5));
      if (r == 0) check_val("rs_err_first", BW'(sync_err_cnt), BW'(1));
      if (r == 254) check_val("rs_err_reach", BW'(sync_err_cnt), BW'(255));
    end
    check_val("rs_err_sat", BW'(sync_err_cnt), BW'(255));
    check_val("rs_err_model", BW'(sync_err_cnt), BW'(exp_err));

    // Reset mid-frame.
    for (int i = 0; i < 6; i++) send_beat(DW'(32'h50 + i), 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    reset   = 1'b1;
    tb_idx  = 0;
    exp_err = 0;
    @(negedge clk);
    check_val("mr_err", BW'(sync_err_cnt), '0);
    check_val("mr_valid", BW'(segments_valid), '0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) send_beat(DW'(32'h100 + i), 1'b0);
    check_val("mr_seg0", BW'(segment_0), BW'(32'h100));
    check_val("mr_seg9", BW'(segment_9), BW'(32'h109));
    check_val("mr_err_after", BW'(sync_err_cnt), '0);

    repeat (4) @(negedge clk);
    check_val("sb_drained", BW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
